// File: rtl/serial_add_ctrl_if.sv
// -----------------------------------------------------------------------------
// serial_add_ctrl_if
//   Request/result bundle between a requesting datapath and serial_add_ctrl.
//
//   Signals
//     start   requester -> adder   request pulse, accepted only while busy=0
//     op_a    requester -> adder   operand A, sampled on the accepting edge
//     op_b    requester -> adder   operand B, sampled on the accepting edge
//     c_in    requester -> adder   carry-in, sampled on the accepting edge
//     sub     requester -> adder   subtract select (only with SERIAL_ADD_SUB_EN)
//     busy    adder -> requester   high while a serial add is in progress
//     done    adder -> requester   one-cycle pulse, result valid
//     sum     adder -> requester   result register
//     c_out   adder -> requester   final carry (no-borrow flag when subtracting)
//
//   Modports: master = requester side, slave = adder side.
//   Optional feature macro: SERIAL_ADD_SUB_EN.
// -----------------------------------------------------------------------------
interface serial_add_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             c_in;
`ifdef SERIAL_ADD_SUB_EN
    logic             sub;
`endif
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             c_out;

    modport master (
        output start, op_a, op_b, c_in,
`ifdef SERIAL_ADD_SUB_EN
        output sub,
`endif
        input  busy, done, sum, c_out
    );

    modport slave (
        input  start, op_a, op_b, c_in,
`ifdef SERIAL_ADD_SUB_EN
        input  sub,
`endif
        output busy, done, sum, c_out
    );
endinterface

// File: rtl/serial_add_ctrl.sv
// -----------------------------------------------------------------------------
// serial_add_ctrl
//   Bit-serial adder controller. A one-bit full-adder slice is stepped over
//   WIDTH cycles, LSB first, with a carry flip-flop chaining each bit's
//   carry-out into the next bit. {c_out,sum} = op_a + op_b + c_in.
//   Start accepted at edge N -> done high in the cycle after edge N+WIDTH;
//   one result per WIDTH+1 cycles. sum/c_out change only on the edge that
//   enters DONE and hold until the next completion.
//
//   Ports
//     clk    system clock, rising edge
//     rst_n  asynchronous active-low reset (clears control and data)
//     bus    serial_add_ctrl_if.slave: start/op_a/op_b/c_in[/sub] in,
//            busy/done/sum/c_out out
//
//   Parameters
//     WIDTH  operand/result width, 2..32
//     CNT_W  bit-counter width, 2**CNT_W > WIDTH
//
//   Optional feature macro: SERIAL_ADD_SUB_EN
//     When defined, bus.sub=1 on the accepting edge computes op_a - op_b
//     (two's complement: B inverted, carry forced to 1); c_out=1 means no
//     borrow. When undefined the block is a pure adder.
// -----------------------------------------------------------------------------
module serial_add_ctrl #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 6
) (
    input  logic               clk,
    input  logic               rst_n,
    serial_add_ctrl_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;

    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] acc_nxt;
    logic [WIDTH-1:0] sum_r;
    logic [CNT_W-1:0] cnt;
    logic             carry;
    logic             carry_nxt;
    logic             bit_s;
    logic             cout_r;
    logic             load;
    logic             last;

    // A request is taken whenever no add is running (IDLE or DONE).
    assign load = (state != RUN) && bus.start;
    assign last = (state == RUN) && (cnt == CNT_W'(WIDTH - 1));

    // One-bit full-adder slice on the current LSBs.
    assign bit_s     = sa[0] ^ sb[0] ^ carry;
    assign carry_nxt = (sa[0] & sb[0]) | (sa[0] & carry) | (sb[0] & carry);

    // New bit enters at the MSB; after WIDTH shifts bit 0 of the result
    // has arrived at acc[0].
    assign acc_nxt = (acc >> 1) | {bit_s, {(WIDTH-1){1'b0}}};

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.start) state_nxt = RUN;
            RUN:     if (last)      state_nxt = DONE;
            DONE:    state_nxt = bus.start ? RUN : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        bus.busy = 1'b0;
        bus.done = 1'b0;
        case (state)
            RUN:     bus.busy = 1'b1;
            DONE:    bus.done = 1'b1;
            default: ;
        endcase
    end

    // Serial datapath: operand shifters, carry flop, bit counter, result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sa     <= '0;
            sb     <= '0;
            acc    <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            sum_r  <= '0;
            cout_r <= 1'b0;
        end else if (load) begin
            sa  <= bus.op_a;
`ifdef SERIAL_ADD_SUB_EN
            sb    <= bus.sub ? ~bus.op_b : bus.op_b;
            carry <= bus.sub ? 1'b1 : bus.c_in;
`else
            sb    <= bus.op_b;
            carry <= bus.c_in;
`endif
            cnt <= '0;
            acc <= '0;
        end else if (state == RUN) begin
            sa    <= sa >> 1;
            sb    <= sb >> 1;
            carry <= carry_nxt;
            acc   <= acc_nxt;
            cnt   <= cnt + CNT_W'(1);
            if (last) begin
                sum_r  <= acc_nxt;
                cout_r <= carry_nxt;
            end
        end
    end

    assign bus.sum   = sum_r;
    assign bus.c_out = cout_r;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// -----------------------------------------------------------------------------
// tb_serial_add_ctrl
//   Bench for serial_add_ctrl (WIDTH=8). A transaction-level model predicts
//   busy/done/sum/c_out every cycle; directed cases pin literal results,
//   latency, back-to-back spacing, ignored requests and asynchronous reset;
//   a randomized loop covers the rest. Subtract cases need SERIAL_ADD_SUB_EN.
// -----------------------------------------------------------------------------
module tb_serial_add_ctrl;
    localparam int WIDTH = 8;
`ifdef SERIAL_ADD_SUB_EN
    localparam bit SUB_EN = 1'b1;
`else
    localparam bit SUB_EN = 1'b0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    serial_add_ctrl_if #(.WIDTH(WIDTH)) bus ();

    serial_add_ctrl #(.WIDTH(WIDTH), .CNT_W(6)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected {c_out,sum} straight from the arithmetic definition.
    function automatic logic [WIDTH:0] ref_result(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                                  input logic ci, input logic sb);
        logic [WIDTH-1:0] nb;
        nb = ~b;
        if (sb) return {1'b0, a} + {1'b0, nb} + (WIDTH+1)'(1);
        return {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, ci};
    endfunction

    // Model: an accepted request keeps the adder busy for WIDTH cycles, then
    // the result appears with a one-cycle done. Requests while busy vanish.
    int             m_left;
    logic           m_done;
    logic [WIDTH:0] m_res;
    logic [WIDTH:0] m_pend;
    logic           cur_sub;

`ifdef SERIAL_ADD_SUB_EN
    assign cur_sub = bus.sub;
`else
    assign cur_sub = 1'b0;
`endif

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_left <= 0;
            m_done <= 1'b0;
            m_res  <= '0;
            m_pend <= '0;
        end else if (m_left != 0) begin
            m_left <= m_left - 1;
            if (m_left == 1) begin
                m_done <= 1'b1;
                m_res  <= m_pend;
            end
        end else begin
            m_done <= 1'b0;
            if (bus.start) begin
                m_left <= WIDTH;
                m_pend <= ref_result(bus.op_a, bus.op_b, bus.c_in, cur_sub);
            end
        end
    end

    // Cycle-by-cycle comparison against the model.
    always @(negedge clk) begin
        chk("cyc_busy", 32'(bus.busy), 32'(m_left != 0));
        chk("cyc_done", 32'(bus.done), 32'(m_done));
        chk("cyc_sum",  32'(bus.sum),  32'(m_res[WIDTH-1:0]));
        chk("cyc_cout", 32'(bus.c_out), 32'(m_res[WIDTH]));
    end

    task automatic set_ops(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                           input logic ci, input logic sb);
        bus.op_a = a;
        bus.op_b = b;
        bus.c_in = ci;
`ifdef SERIAL_ADD_SUB_EN
        bus.sub  = sb;
`else
        if (sb) $display("note: sub requested without SERIAL_ADD_SUB_EN");
`endif
    endtask

    task automatic wait_idle();
        int guard;
        guard = 0;
        @(posedge clk); #1;
        while (bus.busy && guard < 40) begin
            @(posedge clk); #1;
            guard++;
        end
        if (guard >= 40) chk("wait_idle_timeout", 32'(bus.busy), 32'd0);
    endtask

    // One complete operation; checks latency, busy length and the literal result.
    task automatic op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic ci,
                      input logic sb, input logic [WIDTH:0] exp, input bit poke, input string name);
        int k;
        int nbusy;
        bit seen;
        wait_idle();
        set_ops(a, b, ci, sb);
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        set_ops(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), SUB_EN & 1'($urandom));
        k = 0; nbusy = 0; seen = 0;
        while (!seen && k < 20) begin
            @(negedge clk);
            k++;
            if (bus.busy) nbusy++;
            if (bus.done) seen = 1;
            if (poke && k == 3) begin
                bus.start = 1'b1;
                set_ops(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), SUB_EN & 1'($urandom));
            end
            if (poke && k == 4) bus.start = 1'b0;
        end
        chk({name, "_done_seen"}, 32'(seen), 32'd1);
        chk({name, "_latency"}, 32'(k), 32'd9);
        chk({name, "_busy_cycles"}, 32'(nbusy), 32'd8);
        chk({name, "_result"}, 32'({bus.c_out, bus.sum}), 32'(exp));
    endtask

    initial begin
        int k;
        int npulse;
        bit seen;
        logic [WIDTH-1:0] ra, rb;
        logic rc, rs;

        bus.start = 1'b0;
        set_ops('0, '0, 1'b0, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk("reset_busy", 32'(bus.busy), 32'd0);
        chk("reset_done", 32'(bus.done), 32'd0);
        chk("reset_sum",  32'(bus.sum),  32'd0);
        chk("reset_cout", 32'(bus.c_out), 32'd0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // 1: zero add, latency and done width
        op(8'h00, 8'h00, 1'b0, 1'b0, 9'h000, 1'b0, "t1_zero");
        @(negedge clk);
        chk("t1_done_drops", 32'(bus.done), 32'd0);

        // 2: carry propagation cases
        op(8'hFF, 8'h01, 1'b0, 1'b0, 9'h100, 1'b0, "t2_ff_01");
        op(8'hA5, 8'h5A, 1'b1, 1'b0, 9'h100, 1'b0, "t2_a5_5a_c");
        op(8'h7F, 8'h01, 1'b0, 1'b0, 9'h080, 1'b0, "t2_7f_01");

        // 3: back-to-back with start held through DONE
        wait_idle();
        set_ops(8'h10, 8'h20, 1'b0, 1'b0);
        bus.start = 1'b1;
        k = 0; seen = 0;
        while (!seen && k < 20) begin
            @(negedge clk); k++;
            if (bus.done) seen = 1;
        end
        chk("t3_first_done", 32'(seen), 32'd1);
        chk("t3_first_sum", 32'(bus.sum), 32'h30);
        chk("t3_busy_in_done", 32'(bus.busy), 32'd0);
        set_ops(8'h03, 8'h04, 1'b0, 1'b0);
        @(posedge clk); #1;
        bus.start = 1'b0;
        k = 0; seen = 0;
        while (!seen && k < 20) begin
            @(negedge clk); k++;
            if (bus.done) seen = 1;
        end
        chk("t3_spacing", 32'(k), 32'd9);
        chk("t3_second_sum", 32'(bus.sum), 32'h07);

        // 4: start during RUN is ignored
        wait_idle();
        set_ops(8'h11, 8'h22, 1'b0, 1'b0);
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        set_ops(8'hFF, 8'hFF, 1'b1, 1'b0);
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        k = 0; seen = 0;
        while (!seen && k < 20) begin
            @(negedge clk); k++;
            if (bus.done) seen = 1;
        end
        chk("t4_done_seen", 32'(seen), 32'd1);
        chk("t4_result", 32'({bus.c_out, bus.sum}), 32'h033);
        npulse = 0;
        repeat (15) begin @(negedge clk); if (bus.done) npulse++; end
        chk("t4_no_extra_done", 32'(npulse), 32'd0);

        // 5: asynchronous reset mid-run
        wait_idle();
        set_ops(8'hF0, 8'h0F, 1'b0, 1'b0);
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (4) begin @(posedge clk); #1; end
        #2 rst_n = 1'b0;
        #1;
        chk("t5_busy", 32'(bus.busy), 32'd0);
        chk("t5_done", 32'(bus.done), 32'd0);
        chk("t5_sum",  32'(bus.sum),  32'd0);
        chk("t5_cout", 32'(bus.c_out), 32'd0);
        @(posedge clk); #1 rst_n = 1'b1;
        npulse = 0;
        repeat (15) begin @(negedge clk); if (bus.done || bus.busy) npulse++; end
        chk("t5_quiet_after_reset", 32'(npulse), 32'd0);

`ifdef SERIAL_ADD_SUB_EN
        // 6: subtract
        op(8'h05, 8'h07, 1'b0, 1'b1, 9'h0FE, 1'b0, "t6_sub_5_7");
        op(8'h07, 8'h05, 1'b0, 1'b1, 9'h102, 1'b0, "t6_sub_7_5");
        op(8'h05, 8'h07, 1'b0, 1'b0, 9'h00C, 1'b0, "t6_add_5_7");
`endif

        // Randomized operations with idle gaps and ignored mid-run requests
        for (int i = 0; i < 40; i++) begin
            ra = WIDTH'($urandom);
            rb = WIDTH'($urandom);
            rc = 1'($urandom);
            rs = SUB_EN & 1'($urandom);
            repeat ($urandom_range(0, 3)) @(posedge clk);
            op(ra, rb, rc, rs, ref_result(ra, rb, rc, rs), 1'($urandom), "rnd");
        end

        repeat (12) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, compared %0d", n_cmp);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/serial_add_ctrl.md
Name: serial_add_ctrl

Overview:
- Bit-serial adder controller: sequences a one-bit full-adder slice over WIDTH clock cycles, LSB first, to add two WIDTH-bit operands.
- Contains the full-adder slice and a carry flip-flop that feeds each bit's carry-out into the next bit.
- Sits between a requesting datapath and its result consumer.
- Uses a start/busy/done handshake and holds the result stable until the next operation.

Parameters:
- WIDTH, 8, operand/result width in bits; legal range 2..32.
- CNT_W, 6, bit-counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  single system clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request pulse; accepted only when busy=0.
- op_a  input  WIDTH  operand A; sampled on the accepting edge.
- op_b  input  WIDTH  operand B; sampled on the accepting edge.
- c_in  input  1  carry-in; sampled on the accepting edge.
- busy  output  1  high while a serial add is in progress.
- done  output  1  one-cycle pulse; result valid.
- sum  output  WIDTH  result register.
- c_out  output  1  final carry.

Interface decision: one clock (clk); reset rst_n is asynchronous and active-low.

Behaviour:
- Reset (rst_n=0, any time, including mid-operation):
  - State goes to IDLE.
  - busy=0, done=0, sum=0, c_out=0.
  - Shift registers, carry flip-flop and counter all clear to 0.
  - No partial result survives reset.
- States: IDLE, RUN, DONE.
- IDLE: busy=0, done=0. On a start=1 edge:
  - Load sa<=op_a, sb<=op_b, carry<=c_in, cnt<=0, acc<=0.
  - Go to RUN.
- RUN: busy=1. Each cycle:
  - bit = sa[0]^sb[0]^carry.
  - carry <= majority(sa[0], sb[0], carry).
  - acc <= {bit, acc[WIDTH-1:1]}.
  - sa and sb shift right by one with 0 fill.
  - cnt <= cnt+1.
  - The cycle with cnt==WIDTH-1 is the last bit. On that edge: sum <= final acc (including this bit), c_out <= final carry, go to DONE.
- DONE: busy=0, done=1 for exactly this one cycle.
  - If start=1: reload as in IDLE and go to RUN (back-to-back operation).
  - Otherwise go to IDLE.
- Latency: start accepted at edge N -> done=1 during the cycle after edge N+WIDTH. For WIDTH=8, done is high in cycle 9 counting the accept cycle as cycle 0.
- Throughput: one result per WIDTH+1 cycles.
- start while busy=1: ignored. Operands and the running computation are unaffected. No queuing.
- Operand inputs are don't-care except on the accepting edge.
- sum and c_out:
  - Change only on the edge entering DONE.
  - Hold through IDLE, DONE and the following RUN until the next completion.
- Arithmetic: {c_out,sum} = op_a + op_b + c_in, modulo 2^(WIDTH+1). There is no overflow flag.

Optional Feature:
- Macro: SERIAL_ADD_SUB_EN.
- Defined:
  - Adds input port sub (1 bit), sampled on the accepting edge.
  - sub=1: sb loads ~op_b and carry loads 1 (c_in ignored). Result is op_a - op_b modulo 2^WIDTH; c_out=1 means no borrow (op_a >= op_b unsigned).
  - sub=0: identical to plain addition.
- Not defined:
  - No sub port.
  - Behaviour is pure addition exactly as specified above.

Test Plan (WIDTH=8):
1. Reset low, then release; start=1 with 0x00+0x00, c_in=0 -> busy high for 8 cycles; done pulses in cycle 9 with sum=0x00, c_out=0; done low the next cycle.
2. 0xFF+0x01, c_in=0 -> sum=0x00, c_out=1. Then 0xA5+0x5A, c_in=1 -> sum=0x00, c_out=1. Then 0x7F+0x01 -> sum=0x80, c_out=0.
3. Back-to-back: start held high through DONE with 0x10+0x20 then 0x03+0x04 -> done pulses 9 cycles apart; sum=0x30 then 0x07; busy low only in the DONE cycles.
4. Start 0x11+0x22, then pulse start with 0xFF+0xFF at RUN cycle 3 -> second request ignored; sum=0x33, c_out=0; no extra done pulse.
5. Start 0xF0+0x0F, then assert rst_n=0 at RUN cycle 4 -> busy, done, sum and c_out go to 0 immediately (asynchronous). After release, no done pulse occurs without a new start.
6. SERIAL_ADD_SUB_EN defined:
   - sub=1, 0x05-0x07 -> sum=0xFE, c_out=0.
   - sub=1, 0x07-0x05 -> sum=0x02, c_out=1.
   - sub=0, 0x05+0x07 -> sum=0x0C, c_out=0.
